// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: shift-add multiplier,
// restoring divider, with a start/busy/done handshake for MFHI/MFLO stalls.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        abs_a     = (op[0] && a[WIDTH-1]) ? -a : a;
        abs_b     = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc_hi_q[WIDTH-1:0]} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        prod      = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        prod_fix  = (sign_a_q ^ sign_b_q) ? -prod : prod;
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d  = StCalc;
                    is_div_d = op[1];
                    sign_a_d = op[0] & a[WIDTH-1];
                    sign_b_d = op[0] & b[WIDTH-1];
                    acc_hi_d = '0;
                    acc_lo_d = abs_a;
                    opb_d    = abs_b;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                end
            end
            StCalc: begin
                if (!is_div_q) begin
                    // Add then shift the {carry, hi, lo} accumulator right by one.
                    acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end else if (div_trial[WIDTH]) begin
                    acc_hi_d = div_shift;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_hi_d = div_trial;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (opb_q == '0) begin
                    dbz_d = 1'b1;
                end else begin
                    lo_d = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
                    hi_d = sign_a_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a cycle-level arithmetic model checked every cycle,
// plus directed vectors with hand-computed HI/LO values.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on 64-bit integers.
    task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            output logic [W-1:0] rh, output logic [W-1:0] rl, output logic z);
        longint sx, sy, q, r;
        logic [63:0] p;
        z  = 1'b0;
        rh = '0;
        rl = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            2'd2: if (y == 0) z = 1'b1; else begin rl = x / y; rh = x % y; end
            2'd3: if (y == 0) z = 1'b1;
                  else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
        endcase
    endtask

    // Model: a remaining-cycles countdown plus the pending result.
    int           m_cnt = 0;
    logic         m_valid = 1'b0;
    logic         m_done = 1'b0, m_dbz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         p_dbz = 1'b0;

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            m_cnt = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start) begin
                    model_op(op, a, b, p_hi, p_lo, p_dbz);
                    m_cnt = LAT;
                    m_dbz = 1'b0;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    if (p_dbz) m_dbz = 1'b1;
                    else begin m_hi = p_hi; m_lo = p_lo; end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("busy", 64'(busy), 64'(m_cnt != 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            if (m_done) check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        end
    end

    // Issue one op at a negedge, then wait (bounded) for done; lat counts edges after acceptance.
    task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        nbusy = busy ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] eh, input logic [W-1:0] el,
                              input int lat);
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
        check({name, "_model_hi"}, 64'(m_hi), 64'(eh));
        check({name, "_model_lo"}, 64'(m_lo), 64'(el));
    endtask

    initial begin
        int lat, nb, dones;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
        expect_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, lat);
        check("multu_busy_cycles", 64'(nb), 64'(LAT));

        run(2'd1, 32'hFFFF_FFFD, 32'd5, lat, nb);
        expect_res("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, lat);
        run(2'd1, 32'h8000_0000, 32'h8000_0000, lat, nb);
        expect_res("mult_min", 32'h4000_0000, 32'h0, lat);

        run(2'd3, 32'hFFFF_FFF9, 32'd2, lat, nb);
        expect_res("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, lat);
        run(2'd2, 32'd100, 32'd7, lat, nb);
        expect_res("divu", 32'd2, 32'd14, lat);
        run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        expect_res("div_ovf", 32'h0, 32'h8000_0000, lat);
        check("div_ovf_flag", 64'(div_by_zero), 64'd0);

        // Clear LO via reset, then MTHI, then divide by zero.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); hi_we = 1'b0;
        run(2'd2, 32'd5, 32'd0, lat, nb);
        expect_res("divu_zero", 32'h1234, 32'h0, lat);
        check("divu_zero_flag", 64'(div_by_zero), 64'd1);

        // MTHI 0, then MULTU 3*4 with ignored start and hi_we while busy.
        @(negedge clk); hi_we = 1'b1; wdata = 32'h0;
        @(negedge clk); hi_we = 1'b0; start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0; lat = 0;
        check("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 4) begin start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7; end
            if (lat == 5) begin start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD; end
            if (lat == 6) hi_we = 1'b0;
            @(negedge clk);
            lat++;
        end
        expect_res("multu_ignore", 32'h0, 32'd12, lat);
        // Back-to-back start in the done cycle.
        start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7;
        @(negedge clk); start = 1'b0; lat = 0;
        check("b2b_accepted", 64'(busy), 64'd1);
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        expect_res("multu_b2b", 32'h0, 32'd42, lat);

        // Reset mid-divide abandons the operation.
        @(negedge clk); start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done) dones++; end
        check("abort_no_done", 64'(dones), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
